// File: rtl/rtc_bus_writer.sv
// Write-cycle generator for the RTC multiplexed AD bus: address phase, gap, data phase, done.
// Optional one-entry pending request buffer enabled by defining RTC_BUS_WRITER_QUEUE_EN.
module rtc_bus_writer #(
  parameter int unsigned T_PHASE = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [7:0] addr_i,
  input  logic [7:0] datos_i,
  output logic [7:0] ad_out_o,
  output logic       ad_oe_o,
  output logic       cs_n_o,
  output logic       ad_n_o,
  output logic       wr_n_o,
  output logic       rd_n_o,
  output logic       busy_o,
  output logic       done_o
);

  typedef enum logic [2:0] {
    StIdle, StAddrWr, StAddrHold, StGap, StDataWr, StDataHold, StDone
  } state_e;

  localparam logic [7:0] Reload = 8'(T_PHASE - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic [7:0] ad_out_q;
  logic       ad_oe_q, cs_n_q, ad_n_q, wr_n_q, busy_q, done_q;
`ifdef RTC_BUS_WRITER_QUEUE_EN
  logic       qv_q, qv_d;
  logic [7:0] qa_q, qa_d, qd_q, qd_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
`ifdef RTC_BUS_WRITER_QUEUE_EN
    qv_d = qv_q;
    qa_d = qa_q;
    qd_d = qd_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StAddrWr;
          cnt_d   = Reload;
          addr_d  = addr_i;
          data_d  = datos_i;
        end
      end
      StDone: begin
        state_d = StIdle;
        cnt_d   = '0;
`ifdef RTC_BUS_WRITER_QUEUE_EN
        if (qv_q) begin
          state_d = StAddrWr;
          cnt_d   = Reload;
          addr_d  = qa_q;
          data_d  = qd_q;
          qv_d    = 1'b0;
        end else
`endif
        // DONE is the last cycle before IDLE, so a fresh request may launch here.
        if (start_i) begin
          state_d = StAddrWr;
          cnt_d   = Reload;
          addr_d  = addr_i;
          data_d  = datos_i;
        end
      end
      default: begin
        if (cnt_q == 8'd0) begin
          cnt_d = Reload;
          unique case (state_q)
            StAddrWr:   state_d = StAddrHold;
            StAddrHold: state_d = StGap;
            StGap:      state_d = StDataWr;
            StDataWr:   state_d = StDataHold;
            default:    state_d = StDone;
          endcase
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
`ifdef RTC_BUS_WRITER_QUEUE_EN
        if (start_i && !qv_q) begin
          qv_d = 1'b1;
          qa_d = addr_i;
          qd_d = datos_i;
        end
`endif
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      ad_out_q <= '0;
      ad_oe_q  <= 1'b0;
      cs_n_q   <= 1'b1;
      ad_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef RTC_BUS_WRITER_QUEUE_EN
      qv_q <= 1'b0;
      qa_q <= '0;
      qd_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
`ifdef RTC_BUS_WRITER_QUEUE_EN
      qv_q <= qv_d;
      qa_q <= qa_d;
      qd_q <= qd_d;
`endif
      // Outputs are decoded from the next state so they are registered yet phase-aligned.
      ad_out_q <= '0;
      ad_oe_q  <= 1'b0;
      cs_n_q   <= 1'b1;
      ad_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      busy_q   <= (state_d != StIdle);
      done_q   <= (state_d == StDone);
      case (state_d)
        StAddrWr, StAddrHold: begin
          ad_out_q <= addr_d;
          ad_oe_q  <= 1'b1;
          cs_n_q   <= 1'b0;
          ad_n_q   <= 1'b0;
          wr_n_q   <= (state_d == StAddrHold);
        end
        StDataWr, StDataHold: begin
          ad_out_q <= data_d;
          ad_oe_q  <= 1'b1;
          cs_n_q   <= 1'b0;
          wr_n_q   <= (state_d == StDataHold);
        end
        default: ;
      endcase
    end
  end

  assign ad_out_o = ad_out_q;
  assign ad_oe_o  = ad_oe_q;
  assign cs_n_o   = cs_n_q;
  assign ad_n_o   = ad_n_q;
  assign wr_n_o   = wr_n_q;
  assign rd_n_o   = 1'b1;
  assign busy_o   = busy_q;
  assign done_o   = done_q;

endmodule

// File: tb/tb_rtc_bus_writer.sv
// Bench for rtc_bus_writer: two instances (T_PHASE=4 and 1) checked every cycle against a
// timeline model (position since acceptance -> phase), plus directed literal expectations.
module tb_rtc_bus_writer;

`ifdef RTC_BUS_WRITER_QUEUE_EN
  localparam bit QEn = 1'b1;
`else
  localparam bit QEn = 1'b0;
`endif

  // {ad_out[14:7], ad_oe, cs_n, ad_n, wr_n, rd_n, busy, done}
  localparam logic [14:0] Idle = {8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start;
  logic [7:0] addr, datos;
  logic [14:0] obs [2];

  logic [7:0] ao0, ao1;
  logic oe0, cs0, an0, wr0, rd0, bz0, dn0;
  logic oe1, cs1, an1, wr1, rd1, bz1, dn1;

  rtc_bus_writer #(.T_PHASE(4)) dut4 (
    .clk_i(clk), .reset_i(reset), .start_i(start), .addr_i(addr), .datos_i(datos),
    .ad_out_o(ao0), .ad_oe_o(oe0), .cs_n_o(cs0), .ad_n_o(an0), .wr_n_o(wr0),
    .rd_n_o(rd0), .busy_o(bz0), .done_o(dn0)
  );
  rtc_bus_writer #(.T_PHASE(1)) dut1 (
    .clk_i(clk), .reset_i(reset), .start_i(start), .addr_i(addr), .datos_i(datos),
    .ad_out_o(ao1), .ad_oe_o(oe1), .cs_n_o(cs1), .ad_n_o(an1), .wr_n_o(wr1),
    .rd_n_o(rd1), .busy_o(bz1), .done_o(dn1)
  );

  assign obs[0] = {ao0, oe0, cs0, an0, wr0, rd0, bz0, dn0};
  assign obs[1] = {ao1, oe1, cs1, an1, wr1, rd1, bz1, dn1};

  int checks = 0;
  int errors = 0;

  // Model state per instance: active transaction, cycles since its launch edge, operands, buffer.
  int         tp  [2] = '{4, 1};
  bit         act [2];
  int         t   [2];
  logic [7:0] ma  [2], md [2], qa [2], qd [2];
  bit         qv  [2];

  function automatic logic [14:0] expect_out(int k);
    int ph;
    if (!act[k]) return Idle;
    if (t[k] == 5 * tp[k]) return {8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    ph = t[k] / tp[k];
    case (ph)
      0:       return {ma[k], 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      1:       return {ma[k], 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      2:       return {8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      3:       return {md[k], 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      default: return {md[k], 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  task automatic model_edge(input int k, input bit r, input bit s,
                            input logic [7:0] a, input logic [7:0] d);
    if (r) begin
      act[k] = 1'b0;
      qv[k]  = 1'b0;
    end else if (!act[k]) begin
      if (s) begin act[k] = 1'b1; t[k] = 0; ma[k] = a; md[k] = d; end
    end else if (t[k] == 5 * tp[k]) begin
      if (qv[k]) begin
        t[k] = 0; ma[k] = qa[k]; md[k] = qd[k]; qv[k] = 1'b0;
      end else if (s) begin
        t[k] = 0; ma[k] = a; md[k] = d;
      end else begin
        act[k] = 1'b0;
      end
    end else begin
      t[k]++;
      if (QEn && s && !qv[k]) begin qv[k] = 1'b1; qa[k] = a; qd[k] = d; end
    end
  endtask

  // Drive inputs, clock one edge, advance the model, then compare at the falling edge.
  task automatic step(input bit r, input bit s, input logic [7:0] a, input logic [7:0] d);
    reset = r; start = s; addr = a; datos = d;
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_edge(k, r, s, a, d);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== expect_out(k)) begin
        errors++;
        $display("FAIL model_cmp dut%0d got %h want %h t=%0d at %0t",
                 k, obs[k], expect_out(k), t[k], $time);
      end
    end
  endtask

  initial begin
    int bc, first_done, dcount;
    bit saw22;
    reset = 1'b1; start = 1'b0; addr = '0; datos = '0;
    for (int k = 0; k < 2; k++) begin act[k] = 0; t[k] = 0; qv[k] = 0; end
    @(negedge clk);

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00, 8'h00);
    chk("reset_idle_t4", {17'd0, obs[0]}, {17'd0, Idle});
    chk("reset_idle_t1", {17'd0, obs[1]}, {17'd0, Idle});

    // Single write 21/35; T=1 instance gets a back-to-back start at edge 6; 22 arrives at edge 7.
    bc = 0; first_done = -1; saw22 = 0;
    for (int i = 0; i < 30; i++) begin
      logic s;
      logic [7:0] a, d;
      s = (i == 0) || (i == 6) || (i == 7);
      a = (i == 0) ? 8'h21 : (i == 6) ? 8'h44 : (i == 7) ? 8'h22 : 8'($urandom);
      d = (i == 0) ? 8'h35 : 8'($urandom);
      step(1'b0, s, a, d);
      if (i <= 20 && obs[0][1]) bc++;
      if (obs[0][0] && first_done < 0) first_done = i;
      if (obs[0][14:7] == 8'h22) saw22 = 1'b1;
      if (i == 0) chk("t4_addr_phase", {24'd0, obs[0][14:7]}, 32'h21);
      if (i == 12) chk("t4_data_phase", {24'd0, obs[0][14:7]}, 32'h35);
      if (i == 5) chk("t1_done_edge5", {31'd0, obs[1][0]}, 32'd1);
      if (i == 6) chk("t1_b2b_accept", {23'd0, obs[1][1], obs[1][14:7]}, {23'd0, 1'b1, 8'h44});
    end
    chk("t4_busy_cycles", bc, 21);
    chk("t4_done_edge", first_done, 20);
    chk("t4_no_addr22", {31'd0, saw22}, 32'd0);

    for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 8'h00, 8'h00);

    // Reset during DATA_WR (edge 13 is inside 12..15), then a clean transaction.
    step(1'b0, 1'b1, 8'h5A, 8'hA5);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 8'h00, 8'h00);
    chk("t4_in_data_wr", {29'd0, obs[0][4], obs[0][3], obs[0][6]}, {29'd0, 3'b101});
    step(1'b1, 1'b0, 8'h00, 8'h00);
    chk("reset_mid_idle", {17'd0, obs[0]}, {17'd0, Idle});
    dcount = 0;
    for (int i = 0; i < 25; i++) begin
      step(1'b0, 1'b0, 8'h00, 8'h00);
      if (obs[0][0]) dcount++;
    end
    chk("reset_no_done", dcount, 0);
    dcount = 0; first_done = -1;
    for (int i = 0; i < 25; i++) begin
      step(1'b0, (i == 0), 8'h66, 8'h77);
      if (obs[0][0]) begin dcount++; if (first_done < 0) first_done = i; end
    end
    chk("post_reset_done_cnt", dcount, 1);
    chk("post_reset_done_edge", first_done, 20);

`ifdef RTC_BUS_WRITER_QUEUE_EN
    dcount = 0; bc = 0;
    for (int i = 0; i < 50; i++) begin
      step(1'b0, (i == 0) || (i == 3) || (i == 5),
           (i == 0) ? 8'h10 : (i == 3) ? 8'h11 : 8'h12, 8'h99);
      if (obs[0][0]) dcount++;
      if (i <= 41 && obs[0][1]) bc++;
      if (i == 21) chk("q_second_addr", {24'd0, obs[0][14:7]}, 32'h11);
    end
    chk("q_done_pulses", dcount, 2);
    chk("q_busy_continuous", bc, 42);
`endif

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
           8'($urandom), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rtc_bus_writer.md
# rtc_bus_writer

Write-cycle generator for the RTC's multiplexed address/data bus. It accepts an 8-bit register address and an 8-bit data byte from the control logic and drives one complete write transaction (address phase, then data phase) onto the bus strobes. It is the transmit-side counterpart of the 8-bit synchronous capture register that samples the bus on reads. It sits between the top-level controller FSM and the bus pads/tristate.

## Interface
- T_PHASE, 4, clock cycles each bus phase is held; legal range 1..255
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; returns block to idle
- start  in  1  request pulse, sampled on rising clk
- addr  in  8  RTC register address, captured when start is accepted
- datos  in  8  byte to write, captured when start is accepted
- ad_out  out  8  value to drive on the AD bus
- ad_oe  out  1  AD bus output enable (1 = drive ad_out onto pads)
- cs_n  out  1  chip select, active low
- ad_n  out  1  address/data select (0 = address phase)
- wr_n  out  1  write strobe, active low
- rd_n  out  1  read strobe; held at 1 by this block
- busy  out  1  transaction in progress
- done  out  1  one-cycle completion pulse

## Operation
- All outputs are registered. Reset/idle values: ad_out=8'h00, ad_oe=0, cs_n=1, ad_n=1, wr_n=1, rd_n=1, busy=0, done=0.
- States: IDLE, ADDR_WR, ADDR_HOLD, GAP, DATA_WR, DATA_HOLD, DONE.
- IDLE: on start=1, capture addr and datos into internal registers, load the phase counter, and go to ADDR_WR.
- ADDR_WR: cs_n=0, ad_n=0, wr_n=0, ad_oe=1, ad_out=captured addr.
- ADDR_HOLD: same as ADDR_WR except wr_n=1. The RTC latches the address on this wr_n rising edge.
- GAP: cs_n=1, ad_n=1, wr_n=1, ad_oe=0, ad_out=0.
- DATA_WR: cs_n=0, ad_n=1, wr_n=0, ad_oe=1, ad_out=captured datos.
- DATA_HOLD: same as DATA_WR except wr_n=1.
- Dwell time: ADDR_WR, ADDR_HOLD, GAP, DATA_WR and DATA_HOLD each last exactly T_PHASE cycles, counted by an 8-bit down-counter reloaded on every state entry.
- DONE: bus signals at idle values, done=1 for exactly one cycle, then IDLE.
- busy=1 in every state except IDLE.
- start while busy is ignored. Captured addr and datos never change mid-transaction.
- ad_oe is never 1 while ad_n changes. ad_out only changes while ad_oe=0 or on a phase boundary, never within a phase.

## Timing
- Let edge 0 be the clk edge that samples start=1 in IDLE.
- ADDR_WR outputs are visible from edge 0. Each later phase boundary falls at edge n·T_PHASE, for n=1..4.
- DONE is entered at edge 5·T_PHASE, so done is high between edges 5·T_PHASE and 5·T_PHASE+1. IDLE is re-entered at edge 5·T_PHASE+1.
- Default latency (T_PHASE=4): done is high in the 21st cycle after acceptance, and busy is high for 21 cycles.
- A new start is accepted on the first edge at which the block is in IDLE, i.e. at edge 5·T_PHASE+1 at the earliest.
- reset=1 at any edge, including mid-phase: all outputs take their reset values at that edge, state goes to IDLE, the counter clears and no done pulse is issued. reset has priority over start.

## Configuration
- Macro: RTC_BUS_WRITER_QUEUE_EN.
- Defined: adds a one-entry pending buffer.
  - start while busy with the buffer empty captures addr/datos into the buffer.
  - start while the buffer is full is ignored.
  - In DONE with the buffer full: done still pulses, the next state is ADDR_WR with the buffered values, busy stays 1 and the buffer empties.
  - reset clears the buffer.
- Undefined: no buffer; start while busy is always dropped.

## Test plan
- Reset values: hold reset for 3 cycles -> all outputs at idle values (ad_out=00, ad_oe=0, cs_n=ad_n=wr_n=rd_n=1, busy=done=0).
- Single write, T_PHASE=4, addr=8'h21, datos=8'h35: strobe sequence matches Operation with 4-cycle phases; ad_out=21 while ad_n=0, ad_out=35 while ad_n=1; done is high in exactly one cycle, at edge 20 after acceptance; busy is high for 21 cycles.
- T_PHASE=1: each phase lasts 1 cycle; done at edge 5; a back-to-back start is accepted at edge 6.
- Start while busy without the macro: second start at edge 7 with addr=8'h22 -> ignored, only one transaction, and ad_out never shows 22.
- Reset mid-operation: assert reset during DATA_WR -> outputs idle on the next edge, no done pulse; a following start runs a full clean transaction.
- With RTC_BUS_WRITER_QUEUE_EN: starts at edges 0, 3 and 5 (addr 8'h10, 8'h11, 8'h12) -> two transactions (10, then 11) with no IDLE cycle between them; the 12 request is dropped; two done pulses.
